pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline: IF, ID, EXE, MEM, WB.
- Branches resolve in ID, with forwarding into ID.
- Decides each cycle which pipeline registers hold, which get a bubble, and which get squashed.
- Covers four cases: load-use hazards, taken branch/jump, a multicycle mult/div unit (HI/LO), and data-memory wait states.
- Sits beside the ID stage and drives the enables of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

Parameters:
- MUL_CYCLES, 4: total busy cycles of a multiply, counted from acceptance.
- DIV_CYCLES, 32: total busy cycles of a divide.
- DELAY_SLOT, 0: 1 = branch delay slot is executed (no IF/ID flush on taken branch/jump); 0 = IF/ID is flushed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- rs_id, rt_id  in  5  source registers of the instruction in ID
- rt_exe  in  5  destination of the instruction in EXE
- MemRead_exe  in  2  non-zero = EXE instruction is a load
- RegWrite_exe  in  1  EXE instruction writes the register file
- branch_taken_id  in  1  ID branch resolved taken, or ID jump
- md_start  in  1  EXE holds a mult/div this cycle
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
- md_use_id  in  1  ID instruction reads HI/LO or is itself mult/div
- mem_req  in  1  MEM stage has an active load/store
- mem_ready  in  1  data memory completes the access this cycle
- stall_pc, stall_ifid  out  1  hold PC / IF-ID register
- bubble_idex  out  1  load NOP into ID/EXE
- flush_ifid  out  1  load NOP into IF/ID
- stall_idex, stall_exmem  out  1  hold ID/EXE / EXE/MEM register
- bubble_memwb  out  1  load NOP into MEM/WB
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse on the last busy cycle
- stall_cycles  out  32  count of cycles with stall_pc=1, saturating at 0xFFFFFFFF

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, md_cnt=0, md_done=0, stall_cycles=0. All stall/bubble/flush outputs are forced 0 while reset=0.
- Hazard condition terms (combinational):
  - mem_stall = mem_req & ~mem_ready
  - lu_stall = (MemRead_exe!=0) & RegWrite_exe & (rt_exe!=0) & (rt_exe==rs_id | rt_exe==rt_id)
  - md_stall = md_busy & md_use_id & ~md_done
- Priority 1, mem_stall: stall_pc, stall_ifid, stall_idex and stall_exmem are 1, bubble_memwb=1. bubble_idex and flush_ifid are forced 0.
- Priority 2, lu_stall | md_stall (no mem_stall): stall_pc=1, stall_ifid=1, bubble_idex=1, flush_ifid=0. EXE and later stages advance. A load-use stall lasts exactly one cycle.
- Priority 3, branch_taken_id with no stall: flush_ifid = ~DELAY_SLOT. A branch held in ID never flushes.
- The md_cnt/state FSM and its transitions are defined in the next three items; these outputs follow from it.
- md FSM, IDLE to BUSY: in IDLE, md_start & ~mem_stall goes to BUSY with md_cnt = (md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
- md FSM, in BUSY:
  - md_cnt decrements every cycle, including during mem_stall.
  - md_done = (state==BUSY & md_cnt==0), combinational from registered state.
  - Next cycle returns to IDLE.
- md FSM, other cases:
  - md_start while BUSY is ignored.
  - md_start while mem_stall is not accepted; it is re-sampled once EXE advances.
- md_busy = (state==BUSY). On the md_done cycle md_use_id no longer stalls, so a HI/LO read issues the next cycle.
- md_cnt width: $clog2(DIV_CYCLES) bits, with a minimum of 1.
- stall_cycles: increments on each rising edge with stall_pc=1; holds at all-ones.
- Simultaneous events:
  - mem_stall during a load-use hazard: the load-use bubble is deferred until mem_stall clears.
  - branch_taken_id and md_stall together: the branch waits in ID and flushes on the cycle it leaves.
- Reset mid-BUSY aborts the operation; no md_done is emitted.

Test Plan:
- Load-use: lw $5 in EXE, ID = add $6,$5,$1 → one cycle with stall_pc=stall_ifid=bubble_idex=1, then all 0. Repeat with rt_exe=0 → no stall.
- Taken beq, DELAY_SLOT=0: flush_ifid=1 for exactly one cycle. With DELAY_SLOT=1: flush_ifid stays 0.
- div accepted at cycle T: md_busy=1 for cycles T+1..T+32, md_done=1 only at T+32. mfhi in ID is stalled through T+31 and issues at T+32. mult gives a 4-cycle window.
- mem_req=1 with mem_ready low for 3 cycles during a load-use hazard: stall_exmem=bubble_memwb=1 for 3 cycles, bubble_idex=0 throughout, then one load-use bubble.
- md_start during mem_stall: not accepted until mem_ready=1. Next md_start while BUSY: md_cnt unchanged.
- reset pulled low mid-divide with md_cnt=10: md_busy=0 immediately, stall_cycles=0, no md_done pulse after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline with branches resolved in ID.
// Handles load-use, taken branch/jump, the multicycle mult/div unit and data-memory wait states.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic [4:0]  rt_exe,
  input  logic [1:0]  MemRead_exe,
  input  logic        RegWrite_exe,
  input  logic        branch_taken_id,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        md_use_id,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        bubble_idex,
  output logic        flush_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        bubble_memwb,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CNT_LOG = $clog2(DIV_CYCLES);
  localparam int unsigned CNT_W   = (CNT_LOG < 1) ? 1 : CNT_LOG;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q;
  logic [CNT_W-1:0] md_cnt_q;
  logic [31:0]      stall_cycles_q;

  logic mem_stall;
  logic lu_stall;
  logic md_stall;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_stall  = (MemRead_exe != 2'b00) & RegWrite_exe & (rt_exe != 5'd0) &
                     ((rt_exe == rs_id) | (rt_exe == rt_id));

  assign md_busy  = (state_q == BUSY);
  assign md_done  = md_busy & (md_cnt_q == '0);
  // The last busy cycle already lets the HI/LO reader go.
  assign md_stall = md_busy & md_use_id & ~md_done;

  // NOTE: every output gets a default before the priority chain, otherwise
  // an unassigned path would infer a latch.
  always_comb begin
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    stall_idex   = 1'b0;
    stall_exmem  = 1'b0;
    bubble_memwb = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        // Whole front end freezes; a pending load-use bubble waits for EXE to move.
        stall_pc     = 1'b1;
        stall_ifid   = 1'b1;
        stall_idex   = 1'b1;
        stall_exmem  = 1'b1;
        bubble_memwb = 1'b1;
      end else if (lu_stall | md_stall) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end else if (branch_taken_id) begin
        flush_ifid = ~DELAY_SLOT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A start held under a memory wait is re-sampled once EXE advances.
          if (md_start && !mem_stall) begin
            state_q  <= BUSY;
            md_cnt_q <= md_is_div ? DIV_LOAD : MUL_LOAD;
          end
        end
        BUSY: begin
          if (md_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            md_cnt_q <= md_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          md_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if (stall_pc && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with DELAY_SLOT=1 shares the stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_id, rt_id, rt_exe;
  logic [1:0]  MemRead_exe;
  logic        RegWrite_exe, branch_taken_id;
  logic        md_start, md_is_div, md_use_id;
  logic        mem_req, mem_ready;

  logic        stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic        stall_idex, stall_exmem, bubble_memwb, md_busy, md_done;
  logic [31:0] stall_cycles;

  logic        stall_pc_ds, stall_ifid_ds, bubble_idex_ds, flush_ifid_ds;
  logic        stall_idex_ds, stall_exmem_ds, bubble_memwb_ds, md_busy_ds, md_done_ds;
  logic [31:0] stall_cycles_ds;

  // {stall_pc, stall_ifid, bubble_idex, flush_ifid, stall_idex, stall_exmem, bubble_memwb}
  logic [6:0] ctl, ctl_ds;
  assign ctl    = {stall_pc, stall_ifid, bubble_idex, flush_ifid, stall_idex, stall_exmem, bubble_memwb};
  assign ctl_ds = {stall_pc_ds, stall_ifid_ds, bubble_idex_ds, flush_ifid_ds,
                   stall_idex_ds, stall_exmem_ds, bubble_memwb_ds};

  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_LU    = 7'b1110000;
  localparam logic [6:0] CTL_MEM   = 7'b1100111;
  localparam logic [6:0] CTL_FLUSH = 7'b0001000;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sc = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .DELAY_SLOT(1'b0)) dut (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rt_exe(rt_exe),
    .MemRead_exe(MemRead_exe), .RegWrite_exe(RegWrite_exe), .branch_taken_id(branch_taken_id),
    .md_start(md_start), .md_is_div(md_is_div), .md_use_id(md_use_id),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .stall_idex(stall_idex), .stall_exmem(stall_exmem),
    .bubble_memwb(bubble_memwb), .md_busy(md_busy), .md_done(md_done),
    .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .DELAY_SLOT(1'b1)) dut_ds (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rt_exe(rt_exe),
    .MemRead_exe(MemRead_exe), .RegWrite_exe(RegWrite_exe), .branch_taken_id(branch_taken_id),
    .md_start(md_start), .md_is_div(md_is_div), .md_use_id(md_use_id),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc_ds), .stall_ifid(stall_ifid_ds), .bubble_idex(bubble_idex_ds),
    .flush_ifid(flush_ifid_ds), .stall_idex(stall_idex_ds), .stall_exmem(stall_exmem_ds),
    .bubble_memwb(bubble_memwb_ds), .md_busy(md_busy_ds), .md_done(md_done_ds),
    .stall_cycles(stall_cycles_ds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow one more unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = 5'd0; rt_id = 5'd0; rt_exe = 5'd0;
    MemRead_exe = 2'b00; RegWrite_exe = 1'b0; branch_taken_id = 1'b0;
    md_start = 1'b0; md_is_div = 1'b0; md_use_id = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken_id = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin
      n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NONE);
    end
    step(); #1;
    n_cmp++;
    if ({md_busy, md_done, stall_cycles} !== 34'd0) begin
      n_err++; $display("FAIL reset_state: busy=%b done=%b sc=%0d want 0/0/0", md_busy, md_done, stall_cycles);
    end
    clear_inputs();
    #2 reset = 1'b1;
    exp_sc = 0;
  endtask

  task automatic test_load_use();
    // lw $5 in EXE, add $6,$5,$1 in ID
    step();
    MemRead_exe = 2'b01; RegWrite_exe = 1'b1; rt_exe = 5'd5; rs_id = 5'd5; rt_id = 5'd1;
    #1;
    n_cmp++;
    if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rs: got %b want %b", ctl, CTL_LU); end
    exp_sc++;
    step();
    MemRead_exe = 2'b00; RegWrite_exe = 1'b0; rt_exe = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin n_err++; $display("FAIL lu_after: got %b want %b", ctl, CTL_NONE); end
    n_cmp++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_err++; $display("FAIL lu_count: got %0d want %0d", stall_cycles, exp_sc);
    end
    // Match on rt with MemRead encoding 2
    step();
    MemRead_exe = 2'b10; RegWrite_exe = 1'b1; rt_exe = 5'd1; rs_id = 5'd5; rt_id = 5'd1;
    #1;
    n_cmp++;
    if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_rt: got %b want %b", ctl, CTL_LU); end
    exp_sc++;
    // Load to $0 never stalls
    step();
    MemRead_exe = 2'b01; RegWrite_exe = 1'b1; rt_exe = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin n_err++; $display("FAIL lu_zero: got %b want %b", ctl, CTL_NONE); end
    // Matching load that does not write the register file
    step();
    MemRead_exe = 2'b01; RegWrite_exe = 1'b0; rt_exe = 5'd9; rs_id = 5'd9;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin n_err++; $display("FAIL lu_nowrite: got %b want %b", ctl, CTL_NONE); end
    // ALU producer is forwarded, not stalled
    step();
    MemRead_exe = 2'b00; RegWrite_exe = 1'b1; rt_exe = 5'd9; rs_id = 5'd9;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin n_err++; $display("FAIL lu_alu: got %b want %b", ctl, CTL_NONE); end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_err++; $display("FAIL lu_count2: got %0d want %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_branch();
    step();
    branch_taken_id = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, ctl_ds} !== {CTL_FLUSH, CTL_NONE}) begin
      n_err++; $display("FAIL br_flush: got %b/%b want %b/%b", ctl, ctl_ds, CTL_FLUSH, CTL_NONE);
    end
    step();
    branch_taken_id = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== CTL_NONE) begin n_err++; $display("FAIL br_once: got %b want %b", ctl, CTL_NONE); end
    // Branch held by a load-use stall flushes only when it leaves ID
    step();
    branch_taken_id = 1'b1; MemRead_exe = 2'b01; RegWrite_exe = 1'b1; rt_exe = 5'd7; rs_id = 5'd7;
    #1;
    n_cmp++;
    if ({ctl, ctl_ds} !== {CTL_LU, CTL_LU}) begin
      n_err++; $display("FAIL br_held: got %b/%b want %b/%b", ctl, ctl_ds, CTL_LU, CTL_LU);
    end
    exp_sc++;
    step();
    MemRead_exe = 2'b00; RegWrite_exe = 1'b0; rt_exe = 5'd0;
    #1;
    n_cmp++;
    if ({ctl, ctl_ds} !== {CTL_FLUSH, CTL_NONE}) begin
      n_err++; $display("FAIL br_leave: got %b/%b want %b/%b", ctl, ctl_ds, CTL_FLUSH, CTL_NONE);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_div_mfhi();
    step();
    md_start = 1'b1; md_is_div = 1'b1;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_accept: busy=%b want 0", md_busy); end
    for (int k = 1; k <= 32; k++) begin
      step();
      md_start        = (k == 5);      // ignored while busy
      md_is_div       = (k != 5);
      md_use_id       = 1'b1;          // mfhi in ID
      branch_taken_id = (k >= 30);
      #1;
      n_cmp++;
      if ({md_busy, md_done} !== {1'b1, k == 32}) begin
        n_err++; $display("FAIL div_k%0d: busy=%b done=%b want 1/%b", k, md_busy, md_done, k == 32);
      end
      n_cmp++;
      if (ctl !== ((k < 32) ? CTL_LU : CTL_FLUSH) || flush_ifid_ds !== 1'b0) begin
        n_err++; $display("FAIL div_ctl_k%0d: got %b ds_flush=%b want %b", k, ctl, flush_ifid_ds,
                          (k < 32) ? CTL_LU : CTL_FLUSH);
      end
      if (k < 32) exp_sc++;
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if ({md_busy, md_done} !== 2'b00) begin
      n_err++; $display("FAIL div_end: busy=%b done=%b want 0/0", md_busy, md_done);
    end
    n_cmp++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_err++; $display("FAIL div_count: got %0d want %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_mult();
    step();
    md_start = 1'b1; md_is_div = 1'b0;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mul_accept: busy=%b want 0", md_busy); end
    for (int k = 1; k <= 4; k++) begin
      step();
      md_start = 1'b0;
      #1;
      n_cmp++;
      if ({md_busy, md_done, ctl} !== {1'b1, k == 4, CTL_NONE}) begin
        n_err++; $display("FAIL mul_k%0d: busy=%b done=%b ctl=%b want 1/%b/%b", k, md_busy, md_done,
                          ctl, k == 4, CTL_NONE);
      end
    end
    step();
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mul_end: busy=%b want 0", md_busy); end
  endtask

  task automatic test_mem_lu();
    step();
    MemRead_exe = 2'b01; RegWrite_exe = 1'b1; rt_exe = 5'd5; rs_id = 5'd5; rt_id = 5'd1;
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken_id = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      #1;
      n_cmp++;
      if (ctl !== CTL_MEM) begin n_err++; $display("FAIL mem_k%0d: got %b want %b", k, ctl, CTL_MEM); end
      exp_sc++;
    end
    step();
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== CTL_LU) begin n_err++; $display("FAIL mem_lu_bubble: got %b want %b", ctl, CTL_LU); end
    exp_sc++;
    step();
    MemRead_exe = 2'b00; RegWrite_exe = 1'b0; rt_exe = 5'd0; mem_req = 1'b0;
    #1;
    n_cmp++;
    if ({ctl, ctl_ds} !== {CTL_FLUSH, CTL_NONE}) begin
      n_err++; $display("FAIL mem_br_leave: got %b/%b want %b/%b", ctl, ctl_ds, CTL_FLUSH, CTL_NONE);
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (stall_cycles !== 32'(exp_sc)) begin
      n_err++; $display("FAIL mem_count: got %0d want %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_md_mem();
    step();
    md_start = 1'b1; md_is_div = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== CTL_MEM) begin n_err++; $display("FAIL mdmem_ctl: got %b want %b", ctl, CTL_MEM); end
    exp_sc++;
    step();
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mdmem_hold1: busy=%b want 0", md_busy); end
    exp_sc++;
    step();
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (md_busy !== 1'b0) begin n_err++; $display("FAIL mdmem_hold2: busy=%b want 0", md_busy); end
    step();
    md_start = 1'b0; mem_req = 1'b0;
    #1;
    n_cmp++;
    if ({md_busy, md_done} !== 2'b10) begin
      n_err++; $display("FAIL mdmem_k1: busy=%b done=%b want 1/0", md_busy, md_done);
    end
    // Counter keeps running while memory waits
    for (int k = 2; k <= 4; k++) begin
      step();
      mem_req = (k < 4); mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({md_busy, md_done} !== {1'b1, k == 4}) begin
        n_err++; $display("FAIL mdmem_k%0d: busy=%b done=%b want 1/%b", k, md_busy, md_done, k == 4);
      end
      if (k < 4) exp_sc++;
    end
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if ({md_busy, stall_cycles} !== {1'b0, 32'(exp_sc)}) begin
      n_err++; $display("FAIL mdmem_end: busy=%b sc=%0d want 0/%0d", md_busy, stall_cycles, exp_sc);
    end
  endtask

  task automatic test_reset_mid_div();
    step();
    md_start = 1'b1; md_is_div = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      md_start = 1'b0; md_use_id = 1'b1;
      #1;
      if (k < 22) exp_sc++;
    end
    // md_cnt is 10 in this cycle
    n_cmp++;
    if ({md_busy, stall_cycles} !== {1'b1, 32'(exp_sc)}) begin
      n_err++; $display("FAIL rst_pre: busy=%b sc=%0d want 1/%0d", md_busy, stall_cycles, exp_sc);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({md_busy, md_done, ctl, stall_cycles} !== {2'b00, CTL_NONE, 32'd0}) begin
      n_err++; $display("FAIL rst_mid: busy=%b done=%b ctl=%b sc=%0d want 0/0/%b/0", md_busy, md_done,
                        ctl, stall_cycles, CTL_NONE);
    end
    exp_sc = 0;
    step();
    clear_inputs();
    #2 reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      n_cmp++;
      if ({md_busy, md_done} !== 2'b00) begin
        n_err++; $display("FAIL rst_after_%0d: busy=%b done=%b want 0/0", k, md_busy, md_done);
      end
    end
    n_cmp++;
    if (stall_cycles !== 32'd0) begin
      n_err++; $display("FAIL rst_count: got %0d want 0", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_div_mfhi();
    test_mult();
    test_mem_lu();
    test_md_mem();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
